mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
Sequences the MEM pipeline stage of the core.
- Accepts one instruction per transaction from EX.
- Non-memory ops pass through with one registered cycle.
- Loads and stores run a req/ack handshake on the data-RAM bus, with byte-lane steering and load sign/zero extension.
- Produces the registered pc/inst/ram_rd_en/rw_data/rw_addr/rw_en bundle consumed by WB, and back-pressures EX while a bus access is outstanding.

Parameters:
ADDR_W, 32, address width (`ADDR_WIDTH)
DATA_W, 32, data width (`DATA_WIDTH); fixed 32, four byte lanes
REG_W, 5, register index width (`REG_WIDTH)
TIMEOUT, 64, max cycles waiting for bus_ack before bus-error

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  EX presents an instruction
in_ready  out  1  controller can accept (high only in IDLE)
in_pc  in  ADDR_W  instruction pc
in_inst  in  32  instruction word
in_mem_en  in  1  instruction is load/store
in_mem_we  in  1  1=store, 0=load
in_mem_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
in_mem_sext  in  1  sign-extend load result
in_addr  in  ADDR_W  effective address (= ALU result)
in_wdata  in  DATA_W  store data, low-aligned
in_rw_data  in  DATA_W  ALU result for non-memory ops
in_rw_addr  in  REG_W  destination register
in_rw_en  in  1  destination write enable
flush  in  1  squash current instruction
bus_req  out  1  data-RAM request
bus_we  out  1  write request
bus_addr  out  ADDR_W  word-aligned address ({addr[31:2],2'b00})
bus_wstrb  out  4  byte strobes
bus_wdata  out  DATA_W  lane-replicated store data
bus_ack  in  1  request accepted; rdata valid same cycle for loads
bus_rdata  in  DATA_W  read data
out_valid  out  1  one-cycle pulse, result to WB
out_pc  out  ADDR_W  pc of retiring instruction
out_inst  out  32  instruction word
out_ram_rd_en  out  1  retiring op was a load
out_rw_data  out  DATA_W  writeback data
out_rw_addr  out  REG_W  writeback register
out_rw_en  out  1  writeback enable
exc_ale  out  1  misaligned access, valid with out_valid
exc_buserr  out  1  bus timeout, valid with out_valid

Behaviour:
- Reset: state=IDLE; all out_* and exc_* = 0; bus_req=0; timeout counter=0. Reset mid-transaction drops bus_req the next cycle, with no completion.
- States: IDLE, REQ, RESP.
- IDLE
  - in_ready=1. Accept on in_valid & ~flush; latch all in_* fields.
  - Non-memory op → RESP; out_valid occurs the cycle after accept (latency 1).
  - Memory op with misalignment (half: addr[0]≠0; word: addr[1:0]≠0) → RESP with exc_ale=1, out_rw_en=0; no bus request.
  - Aligned memory op → REQ.
- REQ
  - bus_req=1, and addr/we/wstrb/wdata are held stable until bus_ack.
  - On bus_ack: capture the extended load data → RESP.
  - Counter increments each REQ cycle. When it reaches TIMEOUT-1 without ack: drop bus_req, exc_buserr=1, out_rw_en=0 → RESP.
- RESP
  - out_valid=1 for exactly one cycle → IDLE. in_ready stays 0.
  - Minimum memory-op latency is accept + 2 cycles (ack on first REQ cycle).
- Store strobes:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << {addr[1],1'b0}
  - word: 4'b1111
  - wdata: byte replicated ×4, half ×2.
- Load extract: select byte/half at addr[1:0]; zero- or sign-extend per in_mem_sext. out_ram_rd_en=1 for loads. Stores force out_rw_en=0.
- flush:
  - In IDLE: blocks accept.
  - In REQ: the bus transaction still completes (protocol integrity), but the result is squashed.
  - In RESP: squashes the result.
  - Squashed means out_valid stays 0; a pending-squash bit is held until RESP.
- out_* fields hold their last value between pulses; WB never back-pressures.

Decomposition:
- Shared package mem_pkg:
  - size encodings MEM_B/MEM_H/MEM_W
  - state enum mem_state_t {IDLE,REQ,RESP}
- Sub-module mem_lane_align (combinational):
  - store strobe/replication
  - load extract/extend
  - misalignment detect

Test Plan:
1. Non-memory op: in_rw_data=0x1234, rw_addr=5, rw_en=1 → out_valid the next cycle with out_rw_data=0x1234, out_rw_addr=5, bus_req never asserted.
2. Load byte sext, addr=0x1003, bus_rdata=0x80FFFFFF, ack on first REQ cycle → bus_addr=0x1000, out_rw_data=0xFFFFFF80, out_valid at accept+2.
3. Store half, addr=0x2002, wdata=0xABCD, ack after 3 cycles → bus_wstrb=4'b1100, bus_wdata=0xABCDABCD held stable 3 cycles, out_rw_en=0.
4. Load word, addr=0x3001 → exc_ale=1, out_valid at accept+1, no bus_req.
5. Load word, ack never arrives → bus_req high for TIMEOUT cycles, then exc_buserr=1 and out_rw_en=0.
6. Flush asserted in REQ, ack 2 cycles later → bus handshake completes, out_valid stays 0, in_ready returns high; rst asserted in REQ → bus_req=0 and state IDLE the next cycle.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage controller and its lane-steering helper.
package mem_pkg;

  localparam logic [1:0] MEM_B = 2'b00;
  localparam logic [1:0] MEM_H = 2'b01;
  localparam logic [1:0] MEM_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data-RAM bus: store strobes and replication,
// load byte/half extraction with sign/zero extension, misalignment detect.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [31:0] rd_shift;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  // Size 2'b11 falls into the default arm and behaves as a word access.
  always_comb begin
    rd_shift  = rdata >> {addr_lo, 3'b000};
    rd_byte   = rd_shift[7:0];
    rd_half   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    wstrb     = 4'b1111;
    wdata_rep = wdata;
    rdata_ext = rdata;
    misalign  = 1'b0;
    case (size)
      MEM_B: begin
        wstrb     = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{sext & rd_byte[7]}}, rd_byte};
      end
      MEM_H: begin
        wstrb     = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{sext & rd_half[15]}}, rd_half};
        misalign  = addr_lo[0];
      end
      default: begin
        misalign = |addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage sequencer: accepts one instruction from EX, runs the
// data-RAM req/ack handshake for loads/stores and hands a registered
// result bundle to WB.
//
// state | meaning
// IDLE  | ready for EX; accept latches the instruction
// REQ   | bus_req held with stable addr/we/wstrb/wdata until ack or timeout
// RESP  | one-cycle out_valid pulse to WB (suppressed when squashed)
module mem_stage_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [31:0]       in_inst,
  input  logic              in_mem_en,
  input  logic              in_mem_we,
  input  logic [1:0]        in_mem_size,
  input  logic              in_mem_sext,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [DATA_W-1:0] in_rw_data,
  input  logic [REG_W-1:0]  in_rw_addr,
  input  logic              in_rw_en,
  input  logic              flush,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_wstrb,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_pc,
  output logic [31:0]       out_inst,
  output logic              out_ram_rd_en,
  output logic [DATA_W-1:0] out_rw_data,
  output logic [REG_W-1:0]  out_rw_addr,
  output logic              out_rw_en,
  output logic              exc_ale,
  output logic              exc_buserr
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  mem_state_t state_q, state_d;

  logic [ADDR_W-1:0] pc_q, addr_q;
  logic [31:0]       inst_q;
  logic              we_q, sext_q, rw_en_q, squash_q;
  logic [1:0]        size_q;
  logic [DATA_W-1:0] wdata_q, rw_data_q;
  logic [REG_W-1:0]  rw_addr_q;
  logic [CNT_W-1:0]  cnt_q;

  logic        accept, timeout, misalign;
  logic [1:0]  al_addr_lo, al_size;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata, al_rdata;

  // In IDLE the aligner looks at the incoming op (misalign check); afterwards
  // at the latched op so the bus fields stay stable while in_* wander.
  assign al_addr_lo = (state_q == IDLE) ? in_addr[1:0] : addr_q[1:0];
  assign al_size    = (state_q == IDLE) ? in_mem_size  : size_q;

  mem_lane_align u_align (
    .addr_lo   (al_addr_lo),
    .size      (al_size),
    .sext      (sext_q),
    .wdata     (wdata_q),
    .rdata     (bus_rdata),
    .wstrb     (al_wstrb),
    .wdata_rep (al_wdata),
    .rdata_ext (al_rdata),
    .misalign  (misalign)
  );

  assign in_ready  = (state_q == IDLE);
  assign bus_req   = (state_q == REQ);
  assign bus_we    = we_q;
  assign bus_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus_wstrb = we_q ? al_wstrb : 4'b0000;
  assign bus_wdata = al_wdata;
  assign out_valid = (state_q == RESP) && !squash_q && !flush;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; ack wins over timeout on the final REQ cycle.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          accept  = 1'b1;
          state_d = (in_mem_en && !misalign) ? REQ : RESP;
        end
      end
      REQ: begin
        if (bus_ack) begin
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          timeout = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Instruction latch, timeout counter, squash bit and the WB result bundle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= '0;
      inst_q        <= '0;
      we_q          <= 1'b0;
      size_q        <= MEM_W;
      sext_q        <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rw_data_q     <= '0;
      rw_addr_q     <= '0;
      rw_en_q       <= 1'b0;
      squash_q      <= 1'b0;
      cnt_q         <= '0;
      out_pc        <= '0;
      out_inst      <= '0;
      out_ram_rd_en <= 1'b0;
      out_rw_data   <= '0;
      out_rw_addr   <= '0;
      out_rw_en     <= 1'b0;
      exc_ale       <= 1'b0;
      exc_buserr    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q    <= '0;
          squash_q <= 1'b0;
          if (accept) begin
            pc_q      <= in_pc;
            inst_q    <= in_inst;
            we_q      <= in_mem_we;
            size_q    <= in_mem_size;
            sext_q    <= in_mem_sext;
            addr_q    <= in_addr;
            wdata_q   <= in_wdata;
            rw_data_q <= in_rw_data;
            rw_addr_q <= in_rw_addr;
            rw_en_q   <= in_rw_en;
            if (!in_mem_en || misalign) begin
              out_pc        <= in_pc;
              out_inst      <= in_inst;
              out_rw_data   <= in_rw_data;
              out_rw_addr   <= in_rw_addr;
              out_rw_en     <= in_rw_en && !in_mem_en;
              out_ram_rd_en <= in_mem_en && !in_mem_we;
              exc_ale       <= in_mem_en;
              exc_buserr    <= 1'b0;
            end
          end
        end
        REQ: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (flush) squash_q <= 1'b1;
          if ((bus_ack || timeout) && !(squash_q || flush)) begin
            out_pc        <= pc_q;
            out_inst      <= inst_q;
            out_rw_addr   <= rw_addr_q;
            out_ram_rd_en <= !we_q;
            exc_ale       <= 1'b0;
            exc_buserr    <= !bus_ack;
            if (bus_ack && !we_q) begin
              out_rw_data <= al_rdata;
              out_rw_en   <= rw_en_q;
            end else begin
              out_rw_data <= rw_data_q;
              out_rw_en   <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed cases plus randomized
// transactions checked against a byte-level behavioural model.
module tb_mem_stage_ctrl;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_inst = '0;
  logic        in_mem_en = 1'b0;
  logic        in_mem_we = 1'b0;
  logic [1:0]  in_mem_size = 2'b00;
  logic        in_mem_sext = 1'b0;
  logic [31:0] in_addr = '0;
  logic [31:0] in_wdata = '0;
  logic [31:0] in_rw_data = '0;
  logic [4:0]  in_rw_addr = '0;
  logic        in_rw_en = 1'b0;
  logic        flush = 1'b0;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        out_valid;
  logic [31:0] out_pc, out_inst;
  logic        out_ram_rd_en;
  logic [31:0] out_rw_data;
  logic [4:0]  out_rw_addr;
  logic        out_rw_en, exc_ale, exc_buserr;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl #(
    .ADDR_W(32), .DATA_W(32), .REG_W(5), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst),
    .in_mem_en(in_mem_en), .in_mem_we(in_mem_we),
    .in_mem_size(in_mem_size), .in_mem_sext(in_mem_sext),
    .in_addr(in_addr), .in_wdata(in_wdata),
    .in_rw_data(in_rw_data), .in_rw_addr(in_rw_addr), .in_rw_en(in_rw_en),
    .flush(flush),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
    .out_ram_rd_en(out_ram_rd_en), .out_rw_data(out_rw_data),
    .out_rw_addr(out_rw_addr), .out_rw_en(out_rw_en),
    .exc_ale(exc_ale), .exc_buserr(exc_buserr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // One instruction through the stage. ack_n: REQ cycle (1-based) that gets
  // bus_ack, 0 = never. fl_req: REQ cycle with flush, 0 = none.
  // resp_fl: flush on the expected result cycle.
  task automatic txn(input logic mem_en, input logic we, input logic [1:0] size,
                     input logic sext, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] rdata, input logic [31:0] rwd,
                     input logic [4:0] rwa, input logic rwe,
                     input int ack_n, input int fl_req, input logic resp_fl);
    int nbytes, off, lat, exp_req, k, req_cnt, v_cnt, v_k, r_k;
    logic misal, buserr, squashed;
    logic [31:0] exp_data, exp_wd, pc, inst;
    logic [31:0] cap_pc, cap_inst, cap_rwd;
    logic [4:0]  cap_rwa;
    logic        cap_rd, cap_rwe, cap_ale, cap_be;
    logic [3:0]  exp_strb;

    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    off    = int'(addr[1:0]);
    misal  = mem_en && ((nbytes == 2 && (off % 2) != 0) || (nbytes == 4 && off != 0));
    buserr = mem_en && !misal && ack_n == 0;
    if (!mem_en || misal) begin lat = 1; exp_req = 0; end
    else if (buserr)      begin lat = TIMEOUT + 1; exp_req = TIMEOUT; end
    else                  begin lat = ack_n + 1; exp_req = ack_n; end
    squashed = resp_fl || (fl_req != 0 && fl_req <= exp_req);

    exp_strb = '0;
    exp_wd   = '0;
    exp_data = '0;
    for (int i = 0; i < 4; i++) begin
      if (i >= off && i < off + nbytes) exp_strb[i] = 1'b1;
      exp_wd[8*i +: 8] = wdata[8*(i % nbytes) +: 8];
    end
    if (!misal) begin
      for (int i = 0; i < nbytes; i++) exp_data[8*i +: 8] = rdata[8*(off+i) +: 8];
      if (sext && nbytes < 4 && exp_data[8*nbytes-1])
        exp_data = exp_data | (32'hFFFF_FFFF << (8*nbytes));
    end

    pc   = $urandom;
    inst = $urandom;
    in_valid = 1'b1; in_pc = pc; in_inst = inst; in_mem_en = mem_en;
    in_mem_we = we; in_mem_size = size; in_mem_sext = sext; in_addr = addr;
    in_wdata = wdata; in_rw_data = rwd; in_rw_addr = rwa; in_rw_en = rwe;
    flush = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_pc = $urandom; in_inst = $urandom; in_addr = $urandom; in_wdata = $urandom;
    in_rw_data = $urandom; in_mem_size = 2'($urandom_range(0, 3));
    in_mem_we = 1'($urandom_range(0, 1)); in_mem_sext = 1'($urandom_range(0, 1));

    k = 0; req_cnt = 0; v_cnt = 0; v_k = 0; r_k = 0;
    cap_pc = '0; cap_inst = '0; cap_rwd = '0; cap_rwa = '0;
    cap_rd = 1'b0; cap_rwe = 1'b0; cap_ale = 1'b0; cap_be = 1'b0;
    while (r_k == 0 && k < TIMEOUT + 20) begin
      @(negedge clk);
      k++;
      if (bus_req) begin
        req_cnt++;
        chk("bus_addr", bus_addr, addr & 32'hFFFF_FFFC);
        chk("bus_we", 32'(bus_we), 32'(we));
        if (we) begin
          chk("bus_wstrb", 32'(bus_wstrb), 32'(exp_strb));
          chk("bus_wdata", bus_wdata, exp_wd);
        end
      end
      bus_ack   = bus_req && (req_cnt == ack_n);
      bus_rdata = bus_ack ? rdata : $urandom;
      flush     = (bus_req && req_cnt == fl_req) || (resp_fl && k == lat);
      #1;
      if (out_valid) begin
        v_cnt++; v_k = k;
        cap_pc = out_pc; cap_inst = out_inst; cap_rwd = out_rw_data; cap_rwa = out_rw_addr;
        cap_rd = out_ram_rd_en; cap_rwe = out_rw_en; cap_ale = exc_ale; cap_be = exc_buserr;
      end
      if (in_ready) r_k = k;
    end
    bus_ack = 1'b0;
    flush   = 1'b0;

    chk("ready_return", 32'(r_k), 32'(lat + 1));
    chk("req_cycles", 32'(req_cnt), 32'(exp_req));
    chk("valid_pulses", 32'(v_cnt), squashed ? 32'd0 : 32'd1);
    if (!squashed && v_cnt == 1) begin
      chk("latency", 32'(v_k), 32'(lat));
      chk("out_pc", cap_pc, pc);
      chk("out_inst", cap_inst, inst);
      chk("out_rw_addr", 32'(cap_rwa), 32'(rwa));
      chk("exc_ale", 32'(cap_ale), 32'(misal));
      chk("exc_buserr", 32'(cap_be), 32'(buserr));
      chk("ram_rd_en", 32'(cap_rd), 32'(mem_en && !we));
      chk("rw_en", 32'(cap_rwe), 32'(!mem_en ? rwe : ((misal || buserr || we) ? 1'b0 : rwe)));
      if (!mem_en) chk("rw_data", cap_rwd, rwd);
      else if (!we && !misal && !buserr) chk("load_data", cap_rwd, exp_data);
    end
  endtask

  initial begin
    logic        r_mem, r_we, r_sext, r_rf;
    logic [1:0]  r_size;
    int          r_ack, r_fl;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_rw_data", out_rw_data, 32'd0);
    chk("rst_exc", 32'({exc_ale, exc_buserr, out_rw_en, out_ram_rd_en}), 32'd0);

    // Non-memory pass-through.
    txn(1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 32'h0, 32'h1234, 5'd5, 1'b1, 0, 0, 1'b0);
    // Load byte, sign-extended, ack on first REQ cycle.
    txn(1'b1, 1'b0, 2'd0, 1'b1, 32'h1003, 32'h0, 32'h80FF_FFFF, 32'h0, 5'd7, 1'b1, 1, 0, 1'b0);
    // Store half at upper lanes, ack after three REQ cycles.
    txn(1'b1, 1'b1, 2'd1, 1'b0, 32'h2002, 32'h0000_ABCD, 32'h0, 32'h0, 5'd3, 1'b1, 3, 0, 1'b0);
    // Misaligned word load.
    txn(1'b1, 1'b0, 2'd2, 1'b0, 32'h3001, 32'h0, 32'h0, 32'h0, 5'd9, 1'b1, 0, 0, 1'b0);
    // Word load that never gets an ack.
    txn(1'b1, 1'b0, 2'd2, 1'b0, 32'h3000, 32'h0, 32'h0, 32'h0, 5'd9, 1'b1, 0, 0, 1'b0);
    // Flush in REQ, ack two cycles later.
    txn(1'b1, 1'b0, 2'd2, 1'b0, 32'h5000, 32'h0, 32'h1111_2222, 32'h0, 5'd1, 1'b1, 3, 1, 1'b0);
    // Flush during the result cycle.
    txn(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h5555, 5'd2, 1'b1, 0, 0, 1'b1);
    // Size 11 as word, zero-extended half at lane 2.
    txn(1'b1, 1'b1, 2'd3, 1'b0, 32'h6000, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd4, 1'b1, 2, 0, 1'b0);
    txn(1'b1, 1'b0, 2'd1, 1'b0, 32'h7002, 32'h0, 32'h8001_0000, 32'h0, 5'd4, 1'b1, 1, 0, 1'b0);

    // Flush in IDLE blocks accept.
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; in_mem_en = 1'b0; in_rw_en = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("idle_flush_ready", 32'(in_ready), 32'd1);
    chk("idle_flush_valid", 32'(out_valid), 32'd0);

    // Reset while a request is outstanding.
    in_valid = 1'b1; in_mem_en = 1'b1; in_mem_we = 1'b0; in_mem_size = 2'd2; in_addr = 32'h4000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_req_before", 32'(bus_req), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_req_after", 32'(bus_req), 32'd0);
    chk("rst_req_ready", 32'(in_ready), 32'd1);
    chk("rst_req_valid", 32'(out_valid), 32'd0);
    chk("rst_req_rw_en", 32'(out_rw_en), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_no_completion", 32'(out_valid), 32'd0);

    // Randomized transactions.
    for (int t = 0; t < 60; t++) begin
      r_mem  = ($urandom_range(0, 9) < 7);
      r_we   = 1'($urandom_range(0, 1));
      r_size = 2'($urandom_range(0, 3));
      r_sext = 1'($urandom_range(0, 1));
      r_ack  = int'($urandom_range(1, 4));
      r_fl   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0;
      r_rf   = ($urandom_range(0, 15) == 0);
      txn(r_mem, r_we, r_size, r_sext, $urandom, $urandom, $urandom, $urandom,
          5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), r_ack, r_fl, r_rf);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
